// File: rtl/ldm_stm_sequencer.sv
`default_nettype none
// ============================================================================
// ldm_stm_sequencer: beat-by-beat address/register sequencer for LDM/STM
// Revision: 1.0
// ============================================================================
module ldm_stm_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       reglist,
  input  logic [ADDR_W-1:0] base,
  input  logic              p_bit,
  input  logic              u_bit,
  input  logic              ready,
  output logic              busy,
  output logic              valid,
  output logic [3:0]        regnum,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              done,
  output logic [ADDR_W-1:0] wb_addr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_BYTES);

  function automatic logic [3:0] lowest_idx(input logic [15:0] m);
    lowest_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) lowest_idx = 4'(i);
    end
  endfunction

  function automatic logic [4:0] popcnt(input logic [15:0] m);
    popcnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      popcnt = popcnt + {4'd0, m[i]};
    end
  endfunction

  state_t              state_q, state_d;
  logic [15:0]         mask_q, mask_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   wb_q, wb_d;
  logic [3:0]          regnum_q, regnum_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                last_q, last_d;
  logic                done_q, done_d;

  logic [4:0]          n_w;
  logic [ADDR_W-1:0]   span_w;
  logic [15:0]         rem_w;

  always_comb begin
    n_w      = popcnt(reglist);
    span_w   = ADDR_W'(n_w) * STRIDE;
    rem_w    = mask_q & ~(16'd1 << regnum_q);
    state_d  = state_q;
    mask_d   = mask_q;
    addr_d   = addr_q;
    wb_d     = wb_q;
    regnum_d = regnum_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    last_d   = last_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d = reglist;
          busy_d = 1'b1;
          case ({p_bit, u_bit})
            2'b01:   addr_d = base;
            2'b11:   addr_d = base + STRIDE;
            2'b00:   addr_d = base - span_w + STRIDE;
            default: addr_d = base - span_w;
          endcase
          wb_d = u_bit ? (base + span_w) : (base - span_w);
          if (reglist != 16'd0) begin
            state_d  = RUN;
            valid_d  = 1'b1;
            regnum_d = lowest_idx(reglist);
            last_d   = (n_w == 5'd1);
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (ready) begin
          mask_d = rem_w;
          if (rem_w == 16'd0) begin
            state_d = DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            regnum_d = lowest_idx(rem_w);
            addr_d   = addr_q + STRIDE;
            // one bit left after clearing means the next beat is the final one
            last_d   = ((rem_w & (rem_w - 16'd1)) == 16'd0);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mask_q   <= 16'd0;
      addr_q   <= '0;
      wb_q     <= '0;
      regnum_q <= 4'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      addr_q   <= addr_d;
      wb_q     <= wb_d;
      regnum_q <= regnum_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  assign busy    = busy_q;
  assign valid   = valid_q;
  assign regnum  = regnum_q;
  assign addr    = addr_q;
  assign last    = last_q;
  assign done    = done_q;
  assign wb_addr = wb_q;

endmodule
`default_nettype wire

// File: tb/tb_ldm_stm_sequencer.sv
`default_nettype none
// ============================================================================
// tb_ldm_stm_sequencer: randomized scoreboard bench for the LDM/STM sequencer
// Revision: 1.0
// ============================================================================
module tb_ldm_stm_sequencer;
  localparam int ADDR_W = 32;
  localparam int WB     = 4;

  logic              clk = 1'b0;
  logic              reset, start, p_bit, u_bit, ready;
  logic [15:0]       reglist;
  logic [ADDR_W-1:0] base;
  logic              busy, valid, last, done;
  logic [3:0]        regnum;
  logic [ADDR_W-1:0] addr, wb_addr;

  int vectors     = 0;
  int miscompares = 0;

  ldm_stm_sequencer #(.ADDR_W(ADDR_W), .WORD_BYTES(WB)) dut (
    .clk(clk), .reset(reset), .start(start), .reglist(reglist), .base(base),
    .p_bit(p_bit), .u_bit(u_bit), .ready(ready), .busy(busy), .valid(valid),
    .regnum(regnum), .addr(addr), .last(last), .done(done), .wb_addr(wb_addr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 always ready, 1 random ready, 2 stall first beat three cycles
  task automatic run_seq(input logic [15:0] rl, input logic [31:0] b, input logic p,
                         input logic u, input int mode, input bit mid_start);
    logic [3:0]  exp_reg[$];
    logic [31:0] exp_addr[$];
    logic [31:0] lo, wb;
    logic [39:0] got, want;
    int n, k, stalls, cycles, hs;
    n  = $countones(rl);
    lo = u ? (p ? b + WB : b) : (p ? b - 32'(WB * n) : b - 32'(WB * n) + WB);
    wb = u ? b + 32'(WB * n) : b - 32'(WB * n);
    k  = 0;
    for (int i = 0; i < 16; i++) begin
      if (rl[i]) begin
        exp_reg.push_back(4'(i));
        exp_addr.push_back(lo + 32'(WB * k));
        k++;
      end
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_before_start: busy=%b expected 0", busy);
    end
    start = 1'b1; reglist = rl; base = b; p_bit = p; u_bit = u; ready = 1'b0;
    step();
    cycles = 1; stalls = 0; hs = 0;
    start = 1'b0;
    reglist = 16'($urandom); base = $urandom; p_bit = 1'($urandom); u_bit = 1'($urandom);
    while (exp_reg.size() > 0 && cycles < 200) begin
      got  = {valid, busy, done, last, regnum, addr};
      want = {1'b1, 1'b1, 1'b0, 1'(exp_reg.size() == 1), exp_reg[0], exp_addr[0]};
      vectors++;
      if (got !== want || wb_addr !== wb) begin
        miscompares++;
        $display("FAIL beat{v,b,d,l,reg,addr} cyc %0d: got %h wb %h expected %h wb %h",
                 cycles, got, wb_addr, want, wb);
      end
      case (mode)
        0:       ready = 1'b1;
        1:       ready = ($urandom_range(0, 3) != 0);
        default: ready = (stalls >= 3);
      endcase
      if (!ready) stalls++;
      start = mid_start && (exp_reg.size() > 1);
      step();
      cycles++;
      if (ready) begin
        void'(exp_reg.pop_front());
        void'(exp_addr.pop_front());
        hs++;
      end
    end
    start = 1'b0; ready = 1'b0;
    vectors++;
    if ({valid, busy, done} !== 3'b011 || wb_addr !== wb) begin
      miscompares++;
      $display("FAIL done_cycle{v,b,d}: got %b wb %h expected 011 wb %h",
               {valid, busy, done}, wb_addr, wb);
    end
    step();
    cycles++;
    vectors++;
    if ({valid, busy, done} !== 3'b000 || wb_addr !== wb || cycles != n + 2 + stalls || hs != n) begin
      miscompares++;
      $display("FAIL back_to_idle{v,b,d}: got %b wb %h cyc %0d hs %0d expected 000 wb %h cyc %0d hs %0d",
               {valid, busy, done}, wb_addr, cycles, hs, wb, n + 2 + stalls, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; ready = 1'b1; reglist = 16'hFFFF;
    step(); step();
    vectors++;
    if ({busy, valid, last, done, regnum, addr, wb_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got b%b v%b l%b d%b r%h a%h wb%h expected all zero",
               busy, valid, last, done, regnum, addr, wb_addr);
    end
    reset = 1'b0; start = 1'b0; ready = 1'b0;
    step();
  endtask

  task automatic test_ia();
    run_seq(16'h8005, 32'h1000, 1'b0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_modes();
    run_seq(16'h00F0, 32'h2000, 1'b1, 1'b0, 0, 1'b0);
    run_seq(16'h00F0, 32'h2000, 1'b1, 1'b1, 0, 1'b0);
    run_seq(16'h00F0, 32'h2000, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_seq(16'h0003, 32'h0, 1'b0, 1'b1, 2, 1'b0);
  endtask

  task automatic test_empty();
    run_seq(16'h0000, 32'h40, 1'b0, 1'b1, 0, 1'b0);
    run_seq(16'h0000, 32'h80, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_full_wrap();
    run_seq(16'hFFFF, 32'hFFFF_FFF0, 1'b0, 1'b1, 0, 1'b1);
    run_seq(16'hFFFF, 32'h0000_0020, 1'b1, 1'b0, 1, 1'b1);
  endtask

  task automatic test_reset_mid();
    start = 1'b1; reglist = 16'h0F00; base = 32'h3000; p_bit = 1'b0; u_bit = 1'b1; ready = 1'b1;
    step();
    start = 1'b0;
    step();
    vectors++;
    if ({valid, regnum, addr} !== {1'b1, 4'd9, 32'h3004}) begin
      miscompares++;
      $display("FAIL reset_mid_second_beat: got v%b r%h a%h expected v1 r9 a00003004",
               valid, regnum, addr);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if ({valid, busy, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_mid_abort{v,b,d}: got %b expected 000", {valid, busy, done});
    end
    step();
    vectors++;
    if ({valid, busy, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_mid_no_more_beats{v,b,d}: got %b expected 000", {valid, busy, done});
    end
    ready = 1'b0;
    run_seq(16'h0A50, 32'h0000_5000, 1'b1, 1'b0, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] rl;
    int pick;
    for (int t = 0; t < 30; t++) begin
      pick = $urandom_range(0, 9);
      rl = (pick == 0) ? 16'h0000 : (pick == 1) ? 16'hFFFF : 16'($urandom);
      run_seq(rl, $urandom, 1'($urandom), 1'($urandom), 1, 1'($urandom));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; reglist = 16'h0; base = '0;
    p_bit = 1'b0; u_bit = 1'b0; ready = 1'b0;
    test_reset();
    test_ia();
    test_modes();
    test_backpressure();
    test_empty();
    test_full_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
Multi-cycle sequencer for ARM load/store-multiple (LDM/STM) in leg_pipelined. Accepts a 16-bit register list, base address and addressing mode. Emits one register number and word address per transfer beat, lowest register first at the lowest address, under a valid/ready handshake. Also produces the base writeback value. It sits between decode and the memory stage, and holds the pipeline until the list is exhausted.

Parameters:
ADDR_W, 32, address width in bits
WORD_BYTES, 4, byte stride between consecutive transfers

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
start  input  1  request to begin a new LDM/STM; sampled only in IDLE
reglist  input  16  register list; bit i set = transfer Ri
base  input  ADDR_W  base register value
p_bit  input  1  pre-index (1) / post-index (0)
u_bit  input  1  up (1) / down (0)
ready  input  1  downstream accepts current beat
busy  output  1  high while a sequence is in progress (RUN or DONE)
valid  output  1  current beat (regnum, addr) is valid
regnum  output  4  register index of current beat
addr  output  ADDR_W  word address of current beat
last  output  1  current beat is the final beat; qualified by valid
done  output  1  one-cycle pulse when the sequence completes
wb_addr  output  ADDR_W  base writeback value; stable from the cycle after start until the next accepted start

Behaviour:
- Reset (synchronous, active-high, wins over all other inputs): state=IDLE. busy, valid, last and done = 0. regnum=0, addr=0, wb_addr=0. Reset mid-sequence aborts immediately; no further beats are issued.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE: start=1 captures the inputs.
  - Remaining mask := reglist.
  - n := popcount(reglist), 0..16, held in 5 bits.
  - Start address, computed modulo 2^ADDR_W:
    - IA (p=0,u=1): base
    - IB (p=1,u=1): base+WORD_BYTES
    - DA (p=0,u=0): base-WORD_BYTES*n+WORD_BYTES
    - DB (p=1,u=0): base-WORD_BYTES*n
  - wb_addr := u ? base+WORD_BYTES*n : base-WORD_BYTES*n.
  - If reglist≠0, go to RUN. If reglist=0, go to DONE.
- Latency: start accepted in cycle N; first valid beat in cycle N+1.
- RUN:
  - valid=1 every cycle.
  - regnum = index of the lowest set bit in the remaining mask.
  - addr = start address + WORD_BYTES*(beats already accepted).
  - last=1 when exactly one bit remains.
  - On valid&ready: clear that bit, advance addr by WORD_BYTES, and present the next beat in the following cycle (one beat per cycle at full throughput).
  - On valid&!ready: regnum, addr and last hold unchanged.
  - Accepting the last beat goes to DONE.
- DONE: valid=0, done=1 for exactly one cycle, busy=1; then go to IDLE.
- start is ignored in RUN and DONE. It is not queued, and the inputs are not resampled.
- Empty list (reglist=0): no beats. DONE follows in cycle N+1. wb_addr=base.
- Full list (0xFFFF): 16 beats, n=16. Span = 64 bytes.
- Address arithmetic wraps modulo 2^ADDR_W; no error is flagged.
- Total latency at full throughput: n+2 cycles from start to return to IDLE (n≥1).

Test Plan:
- IA, reglist=0x8005, base=0x1000, ready=1 -> beats (R0,0x1000), (R2,0x1004), (R15,0x1008,last). done pulse follows; wb_addr=0x100C.
- DB, reglist=0x00F0, base=0x2000 -> beats (R4,0x1FF0), (R5,0x1FF4), (R6,0x1FF8), (R7,0x1FFC,last); wb_addr=0x1FF0. Repeat with IB -> first addr 0x2004, wb 0x2010. Repeat with DA -> first addr 0x1FF4, wb 0x1FF0.
- Backpressure: IA 0x0003, base=0x0, ready low for 3 cycles on beat R0 -> R0/0x0 held stable with valid=1 for 4 cycles, then R1/0x4 with last=1; exactly 2 handshakes.
- Empty list, base=0x40 -> valid never asserted; done=1 in cycle N+1; wb_addr=0x40; busy low in N+2.
- Full list 0xFFFF, IA, base=0xFFFFFFF0 -> 16 beats R0..R15; addresses wrap to 0x0..0x2C; wb_addr=0x30. Assert start mid-sequence with a different reglist -> ignored.
- Reset asserted during the second beat of a 4-beat sequence -> next cycle valid=0, busy=0, done=0. A subsequent start runs correctly from fresh inputs.
